instr_fetch: RTL and testbench

Instruction fetch unit: the initiator side of the instruction ROM interface. It holds the program counter, drives the ROM read address, and captures the returned instruction into a registered fetch stage for the decoder. It handles sequential advance, absolute jumps, PC-relative branches, stalls and halt. It sits between the instruction ROM and the decode/execute logic.

---
 rtl/instr_fetch.sv | 115 +++++++++++
 tb/tb_instr_fetch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds the PC, drives the ROM address and registers the returned word.
// Optional FETCH_COUNT_EN adds a saturating 16-bit count of loaded instructions (fetch_count).
module instr_fetch #(
  parameter  int ROM_SIZE    = 256,
  parameter  int INSTR_WIDTH = 9,
  parameter  int START_ADDR  = 0,
  localparam int AW          = $clog2(ROM_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   halt,
  input  logic                   jump_en,
  input  logic [AW-1:0]          jump_target,
  input  logic                   branch_en,
  input  logic [AW-1:0]          branch_offset,
  output logic [AW-1:0]          instr_addr,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [AW-1:0]          instr_pc,
  output logic                   instr_valid,
`ifdef FETCH_COUNT_EN
  output logic [15:0]            fetch_count,
`endif
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALTED
  } state_t;

  localparam logic [AW-1:0] START_PC = AW'(START_ADDR);

  state_t        state;
  logic [AW-1:0] pc;

  // ROM address is the PC itself; the ROM answers combinationally within the cycle.
  assign instr_addr = pc;

  // NOTE: all state below is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, matching the hardware it describes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= START_PC;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
`ifdef FETCH_COUNT_EN
      fetch_count <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          instr_valid <= 1'b0;
          if (start) begin
            state <= FETCH;
            pc    <= START_PC;
`ifdef FETCH_COUNT_EN
            fetch_count <= '0;
`endif
          end
        end

        FETCH: begin
          if (halt) begin
            state       <= HALTED;
            instr_valid <= 1'b0;
            done        <= 1'b1;
          end else if (stall) begin
            // Everything holds; a pending redirect stays asserted by its requester.
          end else if (jump_en) begin
            pc          <= jump_target;
            instr_valid <= 1'b0;
          end else if (branch_en) begin
            // Relative to the word just delivered, not the one being addressed.
            pc          <= instr_pc + branch_offset;
            instr_valid <= 1'b0;
          end else begin
            instr_out   <= instr_in;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 1'b1;
`ifdef FETCH_COUNT_EN
            if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
`endif
          end
        end

        HALTED: begin
          instr_valid <= 1'b0;
          if (start) begin
            state <= FETCH;
            pc    <= START_PC;
            done  <= 1'b0;
`ifdef FETCH_COUNT_EN
            fetch_count <= '0;
`endif
          end
        end

        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed test-plan scenarios, then randomized
// traffic compared each cycle against a behavioural model of the fetch rules.
module tb_instr_fetch;

  localparam int N  = 256;
  localparam int AW = 8;
  localparam int IW = 9;

  logic          clk = 1'b0;
  logic          reset, start, stall, halt, jump_en, branch_en;
  logic [AW-1:0] jump_target, branch_offset, instr_addr, instr_pc;
  logic [IW-1:0] instr_in, instr_out;
  logic          instr_valid, done;
`ifdef FETCH_COUNT_EN
  logic [15:0]   fetch_count;
`endif

  logic [IW-1:0] rom [N];
  assign instr_in = rom[instr_addr];

  always #5 clk = ~clk;

  instr_fetch #(.ROM_SIZE(N), .INSTR_WIDTH(IW), .START_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .jump_en(jump_en), .jump_target(jump_target), .branch_en(branch_en),
    .branch_offset(branch_offset), .instr_addr(instr_addr), .instr_in(instr_in),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
`ifdef FETCH_COUNT_EN
    .fetch_count(fetch_count),
`endif
    .done(done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: mode 0 = idle, 1 = fetching, 2 = halted.
  int m_mode, m_pc, m_out, m_ipc, m_valid, m_done, m_cnt;

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_out = 0; m_ipc = 0; m_valid = 0; m_done = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit rs, st, sl, hl, je, be, input int jt, bo);
    if (rs) model_reset();
    else if (m_mode == 0) begin
      m_valid = 0;
      if (st) begin m_mode = 1; m_pc = 0; m_cnt = 0; end
    end else if (m_mode == 2) begin
      m_valid = 0;
      if (st) begin m_mode = 1; m_pc = 0; m_done = 0; m_cnt = 0; end
    end else begin
      if (hl) begin m_mode = 2; m_valid = 0; m_done = 1; end
      else if (sl) begin end
      else if (je) begin m_pc = jt; m_valid = 0; end
      else if (be) begin m_pc = (m_ipc + bo) % N; m_valid = 0; end
      else begin
        m_out = int'(rom[m_pc]); m_ipc = m_pc; m_valid = 1;
        m_pc = (m_pc + 1) % N;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  // One clock: drive inputs, advance model with the same inputs, compare #1 after the edge.
  task automatic step(input bit rs = 0, st = 0, sl = 0, hl = 0, je = 0, be = 0,
                      input int jt = 0, bo = 0);
    reset = rs; start = st; stall = sl; halt = hl;
    jump_en = je; branch_en = be;
    jump_target = AW'(jt); branch_offset = AW'(bo);
    @(posedge clk);
    model_edge(rs, st, sl, hl, je, be, jt, bo);
    #1;
    check("instr_addr",  32'(instr_addr),  32'(m_pc));
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("instr_pc",    32'(instr_pc),    32'(m_ipc));
    check("instr_out",   32'(instr_out),   32'(m_out));
    check("done",        32'(done),        32'(m_done));
`ifdef FETCH_COUNT_EN
    check("fetch_count", 32'(fetch_count), 32'(m_cnt));
`endif
  endtask

  // Run plain cycles until the delivered PC reaches target (bounded).
  task automatic run_to_ipc(input int target);
    int n = 0;
    while (!(m_valid == 1 && m_ipc == target) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      errors++;
      $display("FAIL run_to_ipc: timed out, got %0d expected %0d", m_ipc, target);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) rom[i] = IW'($urandom_range(511));
    for (int i = 0; i < 16; i++) rom[i] = IW'(i);
    rom[255] = 9'h0FF;
    model_reset();

    // Reset values
    step(.rs(1)); step(.rs(1));
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_out",   32'(instr_out),   0);
    check("rst_addr",  32'(instr_addr),  0);
    check("rst_done",  32'(done),        0);

    // Idle ignores redirects and halt
    step(.je(1), .jt(77), .hl(1));
    check("idle_ignore_addr", 32'(instr_addr), 0);

    // Start: first valid two cycles after start cycle
    step(.st(1));
    step();
    check("seq_first_valid", 32'(instr_valid), 1);
    check("seq_first_out",   32'(instr_out),   0);
    check("seq_first_pc",    32'(instr_pc),    0);
    run_to_ipc(5);
    for (int k = 0; k < 3; k++) begin
      step(.sl(1), .je(1), .jt(200));
      check("stall_out",   32'(instr_out),   5);
      check("stall_pc",    32'(instr_pc),    5);
      check("stall_valid", 32'(instr_valid), 1);
      check("stall_addr",  32'(instr_addr),  6);
    end
    step();
    check("resume_out", 32'(instr_out), 6);
`ifdef FETCH_COUNT_EN
    check("count_after_7", 32'(fetch_count), 7);
`endif
    run_to_ipc(15);
    check("seq_15_out", 32'(instr_out), 15);

    // Jump to 255 at instr_pc 3, then wrap
    step(.rs(1)); step(.st(1));
    run_to_ipc(3);
    step(.je(1), .jt(255));
    check("jump_bubble", 32'(instr_valid), 0);
    step();
    check("jump_out", 32'(instr_out), 32'h0FF);
    check("jump_pc",  32'(instr_pc),  255);
    step();
    check("wrap_pc", 32'(instr_pc), 0);

    // Branch -2 from instr_pc 10
    run_to_ipc(10);
    step(.be(1), .bo(8'hFE));
    check("branch_bubble", 32'(instr_valid), 0);
    step();
    check("branch_pc",  32'(instr_pc),  8);
    check("branch_out", 32'(instr_out), 8);

    // Jump beats branch
    step(.je(1), .jt(2), .be(1), .bo(100));
    step();
    check("jump_wins_pc", 32'(instr_pc), 2);

    // Halt with stall at instr_pc 4
    run_to_ipc(4);
    step(.hl(1), .sl(1));
    check("halt_done",  32'(done),        1);
    check("halt_valid", 32'(instr_valid), 0);
    check("halt_addr",  32'(instr_addr),  5);
    step(.je(1), .jt(9));
    check("halted_frozen", 32'(instr_addr), 5);
    step(.st(1));
    check("restart_done", 32'(done), 0);
`ifdef FETCH_COUNT_EN
    check("restart_count", 32'(fetch_count), 0);
`endif
    step();
    check("restart_pc", 32'(instr_pc), 0);
    step(); step();

    // Mid-fetch reset
    step(.rs(1));
    check("midrst_valid", 32'(instr_valid), 0);
    check("midrst_pc",    32'(instr_pc),    0);
    check("midrst_out",   32'(instr_out),   0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step(.rs($urandom_range(99) == 0),
           .st($urandom_range(9) == 0),
           .sl($urandom_range(4) == 0),
           .hl($urandom_range(39) == 0),
           .je($urandom_range(9) == 0),
           .be($urandom_range(7) == 0),
           .jt(int'($urandom_range(N - 1))),
           .bo(int'($urandom_range(N - 1))));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
